divider_result_bcd: RTL and testbench
=====================================

Name: divider_result_bcd

Overview:
Downstream consumer of the 8-bit divider. Captures Quotient/Remainder when the divider signals Done and converts both to packed BCD with a sequential double-dabble engine, one bit per clock. Closes the divider's Done/Ack handshake, so the divider can leave its Qd state only after the result is safely converted. The BCD outputs feed the board's display logic.

Parameters:
WIDTH, 8, binary width of Quotient and Remainder; conversion takes WIDTH clocks.
DIGITS, 3, BCD digits per value; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
ClkPort  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Quotient  input  WIDTH  divider quotient, valid while Done=1
Remainder  input  WIDTH  divider remainder, valid while Done=1
Done  input  1  divider result-valid (divider in Qd)
Ack  output  1  acknowledge to divider
Q_bcd  output  4*DIGITS  packed BCD of captured quotient, digit 0 in [3:0]
R_bcd  output  4*DIGITS  packed BCD of captured remainder
Valid  output  1  high once Q_bcd/R_bcd hold a completed conversion
Qi  output  1  one-hot state: idle
Qc  output  1  one-hot state: converting
Qa  output  1  one-hot state: acknowledging

Behaviour:
- Reset (async, active-high): state=QI; Ack=0, Valid=0, Q_bcd=0, R_bcd=0; internal shift and BCD registers and bit counter cleared. Reset asserted in any state, including mid-QC, aborts immediately and discards any partial result.
- QI: Ack=0. On an edge with Done=1: load Quotient and Remainder into binary shift registers, clear the BCD working registers, set count=0, go to QC. Done=0: stay.
- QC: each edge performs one double-dabble step on both values in parallel:
  - every BCD digit >= 5 gets +3;
  - then {bcd, bin} shifts left 1;
  - count increments.
  - On the edge where count == WIDTH-1, the final step result is written directly to Q_bcd/R_bcd, Valid is set to 1, and state goes to QA.
  - Done is ignored in QC, whether it drops or stays high. Quotient/Remainder changes after the load are ignored.
- QA: Ack=1 (Moore output, decoded from state). On an edge with Done=0, go to QI. Otherwise stay. If Done is already 0 on QA entry, Ack is high for exactly one clock. Ack is never asserted outside QA.
- Latency: Done sampled high at edge k (load) -> Q_bcd/R_bcd updated and Ack high after edge k+WIDTH (k+8 at default).
- Q_bcd, R_bcd and Valid hold their values across QI/QC until the next conversion completes. Valid clears only on reset.
- Digit add-3 is per 4-bit digit with no carry between digits. Intermediate working width is 4*DIGITS+WIDTH bits. No overflow is possible when the DIGITS constraint holds.
- Exactly one of Qi/Qc/Qa is high at all times after reset.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined: adds outputs Q_blank and R_blank, each DIGITS wide. Bit i = 1 when digit i and every higher digit are zero. Digit 0 is never blanked. These outputs are registered on the same edge as Q_bcd/R_bcd and reset to 0.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset; Quotient=3, Remainder=10, Done=1 -> after 9 edges Q_bcd=12'h003, R_bcd=12'h010, Valid=1, Ack=1; drop Done -> QI next edge, Ack=0.
2. Quotient=5, Remainder=0 (150/30) -> Q_bcd=12'h005, R_bcd=12'h000. Then Quotient=3, Remainder=20 (140/40) -> Q_bcd=12'h003, R_bcd=12'h020, and the first result is replaced only at completion.
3. Quotient=255, Remainder=128 -> Q_bcd=12'h255, R_bcd=12'h128, verifying add-3 on all digits.
4. Done pulse of 1 clock -> conversion still completes; Ack high exactly 1 clock in QA. Done held 5 clocks past Ack -> Ack stays high until the edge after Done falls.
5. Assert Reset at count=4 in QC -> immediate QI, Ack=0, Valid=0, outputs 0. Next Done yields a correct fresh conversion.
6. With LEAD_ZERO_BLANK_EN: Quotient=7, Remainder=45 -> Q_blank=3'b110, R_blank=3'b100. Quotient=0 -> Q_blank=3'b110.

Source files
------------

// File: rtl/divider_result_bcd.sv
// rtl/divider_result_bcd.sv - captures divider Quotient/Remainder on Done and converts both to packed BCD
//
// Purpose:
//   Consumer side of the 8-bit divider's Done/Ack handshake. On Done it latches
//   the binary result, runs a sequential double-dabble conversion (one bit per
//   clock, both values in parallel), publishes the BCD result, then raises Ack
//   until the divider drops Done.
//
// Ports:
//   ClkPort    in   system clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   Quotient   in   [WIDTH-1:0]    divider quotient, valid while Done=1
//   Remainder  in   [WIDTH-1:0]    divider remainder, valid while Done=1
//   Done       in   divider result-valid
//   Ack        out  acknowledge to divider (high only in QA)
//   Q_bcd      out  [4*DIGITS-1:0] packed BCD quotient, digit 0 in [3:0]
//   R_bcd      out  [4*DIGITS-1:0] packed BCD remainder
//   Valid      out  high once Q_bcd/R_bcd hold a completed conversion
//   Qi/Qc/Qa   out  one-hot state: idle / converting / acknowledging
//   Q_blank    out  [DIGITS-1:0] leading-zero blank mask for Q_bcd (LEAD_ZERO_BLANK_EN only)
//   R_blank    out  [DIGITS-1:0] leading-zero blank mask for R_bcd (LEAD_ZERO_BLANK_EN only)
//
// Optional feature macro: LEAD_ZERO_BLANK_EN

module divider_result_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                ClkPort,
  input  logic                Reset,
  input  logic [WIDTH-1:0]    Quotient,
  input  logic [WIDTH-1:0]    Remainder,
  input  logic                Done,
  output logic                Ack,
  output logic [4*DIGITS-1:0] Q_bcd,
  output logic [4*DIGITS-1:0] R_bcd,
  output logic                Valid,
`ifdef LEAD_ZERO_BLANK_EN
  output logic [DIGITS-1:0]   Q_blank,
  output logic [DIGITS-1:0]   R_blank,
`endif
  output logic                Qi,
  output logic                Qc,
  output logic                Qa
);

  localparam int BW = 4 * DIGITS;      // BCD field width
  localparam int WW = BW + WIDTH;      // working width {bcd, bin}
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_QI = 3'b001,
    S_QC = 3'b010,
    S_QA = 3'b100
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] q_bin, r_bin;
  logic [BW-1:0]    q_work, r_work;
  logic [CW-1:0]    count;
  logic [WW-1:0]    q_step, r_step;
  logic             last_step;

  // One double-dabble iteration: every digit >= 5 gets +3 (no carry between
  // digits), then the whole {bcd, bin} word shifts left by one.
  function automatic logic [WW-1:0] dd_step(input logic [BW-1:0]    bcd,
                                            input logic [WIDTH-1:0] bin);
    logic [BW-1:0] adj;
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    return {adj, bin} << 1;
  endfunction

`ifdef LEAD_ZERO_BLANK_EN
  // Bit d set when digit d and every higher digit are zero; digit 0 always shown.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BW-1:0] bcd);
    logic [DIGITS-1:0] m;
    logic              all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      all_zero = all_zero && (bcd[4*d +: 4] == 4'd0);
      m[d]     = all_zero;
    end
    return m;
  endfunction
`endif

  always_comb begin
    q_step = dd_step(q_work, q_bin);
    r_step = dd_step(r_work, r_bin);
  end

  assign last_step = (count == LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset)
      state <= S_QI;
    else
      state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. Done is deliberately ignored while converting.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_QI: if (Done)      state_nxt = S_QC;
      S_QC: if (last_step) state_nxt = S_QA;
      S_QA: if (!Done)     state_nxt = S_QI;
      default:             state_nxt = S_QI;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: Moore outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    Ack = 1'b0;
    Qi  = 1'b0;
    Qc  = 1'b0;
    Qa  = 1'b0;
    unique case (state)
      S_QI: Qi = 1'b1;
      S_QC: Qc = 1'b1;
      S_QA: begin
        Qa  = 1'b1;
        Ack = 1'b1;
      end
      default: Qi = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: capture, shift/convert, publish. The published result is taken
  // straight from the final step so it lands on the same edge as QC->QA, and
  // the previous result stays visible until then.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      q_bin   <= '0;
      r_bin   <= '0;
      q_work  <= '0;
      r_work  <= '0;
      count   <= '0;
      Q_bcd   <= '0;
      R_bcd   <= '0;
      Valid   <= 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
      Q_blank <= '0;
      R_blank <= '0;
`endif
    end else begin
      if (state == S_QI && Done) begin
        q_bin  <= Quotient;
        r_bin  <= Remainder;
        q_work <= '0;
        r_work <= '0;
        count  <= '0;
      end else if (state == S_QC) begin
        q_work <= q_step[WW-1 -: BW];
        r_work <= r_step[WW-1 -: BW];
        q_bin  <= q_step[WIDTH-1:0];
        r_bin  <= r_step[WIDTH-1:0];
        count  <= count + CW'(1);
        if (last_step) begin
          Q_bcd   <= q_step[WW-1 -: BW];
          R_bcd   <= r_step[WW-1 -: BW];
          Valid   <= 1'b1;
`ifdef LEAD_ZERO_BLANK_EN
          Q_blank <= blank_mask(q_step[WW-1 -: BW]);
          R_blank <= blank_mask(r_step[WW-1 -: BW]);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_result_bcd.sv
// tb/tb_divider_result_bcd.sv - self-checking bench for divider_result_bcd
module tb_divider_result_bcd;

  logic        ClkPort = 1'b0;
  logic        Reset;
  logic [7:0]  Quotient, Remainder;
  logic        Done;
  logic        Ack, Valid, Qi, Qc, Qa;
  logic [11:0] Q_bcd, R_bcd;
`ifdef LEAD_ZERO_BLANK_EN
  logic [2:0]  Q_blank, R_blank;
`endif

  divider_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .ClkPort   (ClkPort),
    .Reset     (Reset),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Done      (Done),
    .Ack       (Ack),
    .Q_bcd     (Q_bcd),
    .R_bcd     (R_bcd),
    .Valid     (Valid),
`ifdef LEAD_ZERO_BLANK_EN
    .Q_blank   (Q_blank),
    .R_blank   (R_blank),
`endif
    .Qi        (Qi),
    .Qc        (Qc),
    .Qa        (Qa)
  );

  always #5 ClkPort = ~ClkPort;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic [11:0] eq;
    logic [11:0] er;
    logic [2:0]  bq;
    logic [2:0]  br;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [2:0] exp_iac);
    chk(name, {29'd0, Qi, Qc, Qa}, {29'd0, exp_iac});
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ClkPort);
      #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input logic [11:0] prev_q, input logic [11:0] prev_r);
    Quotient  = v.q;
    Remainder = v.r;
    Done      = 1'b1;
    tick(1);                              // load edge
    chk_state("load_state", 3'b010);
    Quotient  = ~v.q;                     // must be ignored after load
    Remainder = ~v.r;
    tick(7);
    chk_state("mid_state", 3'b010);
    chk("hold_q_bcd", Q_bcd, prev_q);
    chk("hold_r_bcd", R_bcd, prev_r);
    chk("mid_ack", Ack, 1'b0);
    tick(1);                              // final step edge
    chk("q_bcd", Q_bcd, v.eq);
    chk("r_bcd", R_bcd, v.er);
    chk("valid", Valid, 1'b1);
    chk("ack_qa", Ack, 1'b1);
    chk_state("qa_state", 3'b001);
`ifdef LEAD_ZERO_BLANK_EN
    chk("q_blank", Q_blank, v.bq);
    chk("r_blank", R_blank, v.br);
`endif
    Done = 1'b0;
    tick(1);
    chk("ack_drop", Ack, 1'b0);
    chk_state("back_idle", 3'b100);
  endtask

  initial begin
    vecs[0] = '{q: 8'd3,   r: 8'd10,  eq: 12'h003, er: 12'h010, bq: 3'b110, br: 3'b100};
    vecs[1] = '{q: 8'd5,   r: 8'd0,   eq: 12'h005, er: 12'h000, bq: 3'b110, br: 3'b110};
    vecs[2] = '{q: 8'd3,   r: 8'd20,  eq: 12'h003, er: 12'h020, bq: 3'b110, br: 3'b100};
    vecs[3] = '{q: 8'd255, r: 8'd128, eq: 12'h255, er: 12'h128, bq: 3'b000, br: 3'b000};
    vecs[4] = '{q: 8'd7,   r: 8'd45,  eq: 12'h007, er: 12'h045, bq: 3'b110, br: 3'b100};
    vecs[5] = '{q: 8'd0,   r: 8'd99,  eq: 12'h000, er: 12'h099, bq: 3'b110, br: 3'b100};
    vecs[6] = '{q: 8'd100, r: 8'd9,   eq: 12'h100, er: 12'h009, bq: 3'b000, br: 3'b110};

    Reset     = 1'b1;
    Done      = 1'b0;
    Quotient  = '0;
    Remainder = '0;
    tick(2);
    chk_state("rst_state", 3'b100);
    chk("rst_ack", Ack, 1'b0);
    chk("rst_valid", Valid, 1'b0);
    chk("rst_q_bcd", Q_bcd, 12'h000);
    chk("rst_r_bcd", R_bcd, 12'h000);
`ifdef LEAD_ZERO_BLANK_EN
    chk("rst_q_blank", Q_blank, 3'b000);
    chk("rst_r_blank", R_blank, 3'b000);
`endif
    Reset = 1'b0;
    tick(2);
    chk_state("idle_no_done", 3'b100);

    begin
      logic [11:0] pq, pr;
      pq = 12'h000;
      pr = 12'h000;
      for (int i = 0; i < 7; i++) begin
        run_vec(vecs[i], pq, pr);
        pq = vecs[i].eq;
        pr = vecs[i].er;
      end
    end

    // Single-clock Done pulse: conversion completes, Ack lasts one clock.
    Quotient  = 8'd42;
    Remainder = 8'd7;
    Done      = 1'b1;
    tick(1);
    Done      = 1'b0;
    Quotient  = 8'd99;
    tick(8);
    chk("pulse_q_bcd", Q_bcd, 12'h042);
    chk("pulse_r_bcd", R_bcd, 12'h007);
    chk("pulse_ack", Ack, 1'b1);
    tick(1);
    chk("pulse_ack_1clk", Ack, 1'b0);
    chk_state("pulse_idle", 3'b100);
    tick(1);
    chk_state("pulse_stay_idle", 3'b100);

    // Done held past Ack: Ack stays until the edge after Done falls.
    Quotient  = 8'd64;
    Remainder = 8'd5;
    Done      = 1'b1;
    tick(9);
    chk("held_q_bcd", Q_bcd, 12'h064);
    chk("held_r_bcd", R_bcd, 12'h005);
    chk("held_ack", Ack, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("held_ack_stay", Ack, 1'b1);
    end
    Done = 1'b0;
    #1;
    chk("held_ack_before_edge", Ack, 1'b1);
    tick(1);
    chk("held_ack_drop", Ack, 1'b0);
    chk_state("held_idle", 3'b100);

    // Reset mid-conversion at count=4.
    Quotient  = 8'd200;
    Remainder = 8'd33;
    Done      = 1'b1;
    tick(1);
    Done = 1'b0;
    tick(4);
    chk_state("pre_abort_state", 3'b010);
    Reset = 1'b1;
    #1;
    chk_state("abort_state", 3'b100);
    chk("abort_ack", Ack, 1'b0);
    chk("abort_valid", Valid, 1'b0);
    chk("abort_q_bcd", Q_bcd, 12'h000);
    chk("abort_r_bcd", R_bcd, 12'h000);
    #2;
    Reset = 1'b0;
    tick(1);
    chk_state("post_abort_idle", 3'b100);
    chk("post_abort_valid", Valid, 1'b0);
    Quotient  = 8'd19;
    Remainder = 8'd86;
    Done      = 1'b1;
    tick(9);
    chk("fresh_q_bcd", Q_bcd, 12'h019);
    chk("fresh_r_bcd", R_bcd, 12'h086);
    chk("fresh_valid", Valid, 1'b1);
    chk("fresh_ack", Ack, 1'b1);
    Done = 1'b0;
    tick(1);
    chk_state("fresh_idle", 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Exactly one state flag high whenever reset is not asserted.
  always @(negedge ClkPort) begin
    if (!Reset) begin
      checks++;
      if (!$onehot({Qi, Qc, Qa})) begin
        errors++;
        $display("FAIL onehot: got %b expected one-hot", {Qi, Qc, Qa});
      end
    end
  end

endmodule
